// File: rtl/display_pkg.sv
// ============================================================================
// Module : display_pkg
// Brief  : Shared constants, slot-state enum and width helper for the display
//          scan multiplexer.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package display_pkg;

    localparam int DEFAULT_NUM_DIGITS = 4;

    // Widest supported anode bus, all anodes off (active-low).
    localparam logic [7:0] AN_ALL_OFF = 8'hFF;

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_ON    = 1'b1
    } slot_state_e;

    // Bit width needed to hold 0..n-1, never less than one.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/scan_tick_gen.sv
// ============================================================================
// Module : scan_tick_gen
// Brief  : Per-slot cycle counter; flags the last cycle of a slot and the last
//          cycle of the blanking window.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module scan_tick_gen
    import display_pkg::*;
#(
    parameter int PRESCALE     = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    output logic o_slot_wrap,
    output logic o_blank_end
);

    localparam int                CNT_W  = clog2(PRESCALE);
    localparam logic [CNT_W-1:0]  C_LAST = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (r_cnt == C_LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_slot_wrap = (r_cnt == C_LAST);

    // Strobe on the cycle before the count reaches BLANK_CYCLES so the
    // registered state turns ON exactly when the count does.
    generate
        if (BLANK_CYCLES > 0) begin : g_blank
            localparam logic [CNT_W-1:0] C_BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
            assign o_blank_end = (r_cnt == C_BLANK_LAST);
        end else begin : g_no_blank
            assign o_blank_end = 1'b0;
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/display_scan_mux.sv
// ============================================================================
// Module : display_scan_mux
// Brief  : Time-multiplexes an N-digit hex value onto a shared 7-segment bus
//          with per-slot blanking and frame-boundary double buffering.
//          Optional macro LEADING_ZERO_BLANK_EN suppresses leading zeros.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module display_scan_mux
    import display_pkg::*;
#(
    parameter int NUM_DIGITS   = DEFAULT_NUM_DIGITS,
    parameter int PRESCALE     = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [4*NUM_DIGITS-1:0]      value_in,
    input  logic                         load,
    output logic                         pending,
    output logic [3:0]                   digit_out,
    output logic [NUM_DIGITS-1:0]        an,
    output logic [clog2(NUM_DIGITS)-1:0] digit_idx,
    output logic                         frame_start
);

    localparam int                    IDX_W      = clog2(NUM_DIGITS);
    localparam logic [NUM_DIGITS-1:0] C_AN_OFF   = AN_ALL_OFF[NUM_DIGITS-1:0];
    localparam logic [IDX_W-1:0]      C_IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    slot_state_e                r_state;
    logic [IDX_W-1:0]           r_idx;
    logic [4*NUM_DIGITS-1:0]    r_display;
    logic [4*NUM_DIGITS-1:0]    r_pend_val;
    logic                       r_pending;
    logic [3:0]                 r_digit;
    logic [NUM_DIGITS-1:0]      r_an;
    logic                       r_frame_start;

    logic                       w_slot_wrap;
    logic                       w_blank_end;
    logic                       w_boundary;
    slot_state_e                w_state_next;
    logic [IDX_W-1:0]           w_idx_next;
    logic [4*NUM_DIGITS-1:0]    w_display_next;
    logic [4*NUM_DIGITS-1:0]    w_pend_val_next;
    logic                       w_pending_next;
    logic [NUM_DIGITS-1:0]      w_an_next;
    logic [3:0]                 w_digit_next;

`ifdef LEADING_ZERO_BLANK_EN
    // Bit k set when digit k (k > 0) and every digit above it are zero.
    function automatic logic [NUM_DIGITS-1:0] lz_mask(input logic [4*NUM_DIGITS-1:0] v);
        logic seen;
        seen    = 1'b0;
        lz_mask = '0;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            seen       = seen | (v[4*k +: 4] != 4'h0);
            lz_mask[k] = ~seen;
        end
    endfunction
`endif

    scan_tick_gen #(
        .PRESCALE     (PRESCALE),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_tick (
        .clk         (clk),
        .reset       (reset),
        .o_slot_wrap (w_slot_wrap),
        .o_blank_end (w_blank_end)
    );

    assign w_boundary = w_slot_wrap && (r_idx == C_IDX_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_BLANK;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (BLANK_CYCLES == 0) begin
            w_state_next = ST_ON;
        end else if (w_slot_wrap) begin
            w_state_next = ST_BLANK;
        end else if (w_blank_end) begin
            w_state_next = ST_ON;
        end
    end

    // Outputs are computed from next-cycle state so that the registered
    // anode and digit line up with the counter value they belong to.
    always_comb begin
        w_idx_next      = r_idx;
        w_display_next  = r_display;
        w_pend_val_next = r_pend_val;
        w_pending_next  = r_pending;
        w_an_next       = C_AN_OFF;

        if (w_slot_wrap) begin
            w_idx_next = w_boundary ? '0 : r_idx + IDX_W'(1);
        end

        // A load landing on the boundary bypasses the buffer entirely.
        if (w_boundary) begin
            if (load) begin
                w_display_next = value_in;
                w_pending_next = 1'b0;
            end else if (r_pending) begin
                w_display_next = r_pend_val;
                w_pending_next = 1'b0;
            end
        end else if (load) begin
            w_pend_val_next = value_in;
            w_pending_next  = 1'b1;
        end

        if (w_state_next == ST_ON) begin
            w_an_next[w_idx_next] = 1'b0;
        end
`ifdef LEADING_ZERO_BLANK_EN
        w_an_next = w_an_next | lz_mask(w_display_next);
`endif
        w_digit_next = w_display_next[{w_idx_next, 2'b00} +: 4];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx         <= '0;
            r_display     <= '0;
            r_pend_val    <= '0;
            r_pending     <= 1'b0;
            r_digit       <= 4'h0;
            r_an          <= C_AN_OFF;
            r_frame_start <= 1'b0;
        end else begin
            r_idx         <= w_idx_next;
            r_display     <= w_display_next;
            r_pend_val    <= w_pend_val_next;
            r_pending     <= w_pending_next;
            r_digit       <= w_digit_next;
            r_an          <= w_an_next;
            r_frame_start <= w_boundary;
        end
    end

    assign pending     = r_pending;
    assign digit_out   = r_digit;
    assign an          = r_an;
    assign digit_idx   = r_idx;
    assign frame_start = r_frame_start;

endmodule

`default_nettype wire

// File: tb/tb_display_scan_mux.sv
// ============================================================================
// Module : tb_display_scan_mux
// Brief  : Self-checking bench for display_scan_mux (4 digits, 8-cycle slots,
//          2 blank cycles); honours LEADING_ZERO_BLANK_EN when defined.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_display_scan_mux;

    localparam int ND    = 4;
    localparam int PS    = 8;
    localparam int BC    = 2;
    localparam int FRAME = ND * PS;
`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load = 1'b0;
    logic [15:0] value_in = 16'h0;
    logic        pending;
    logic [3:0]  digit_out;
    logic [3:0]  an;
    logic [1:0]  digit_idx;
    logic        frame_start;

    int checks   = 0;
    int failures = 0;

    // Reference state: cycle number since reset release plus buffer contents.
    int          t;
    logic [15:0] m_disp;
    logic [15:0] m_pval;
    logic        m_pend;

    typedef struct {
        int          cyc;
        logic        ld;
        logic [15:0] val;
        logic [3:0]  an;
        logic [3:0]  dig;
        logic [1:0]  idx;
        logic        pend;
        logic        fs;
    } vec_t;

    vec_t vt[$];

    always #5 clk = ~clk;

    display_scan_mux #(
        .NUM_DIGITS   (ND),
        .PRESCALE     (PS),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .value_in    (value_in),
        .load        (load),
        .pending     (pending),
        .digit_out   (digit_out),
        .an          (an),
        .digit_idx   (digit_idx),
        .frame_start (frame_start)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, t, act, exp);
        end
    endtask

    function automatic logic [3:0] exp_an(input int tt, input logic [15:0] disp);
        int          cnt;
        int          idx;
        logic [3:0]  one;
        cnt = tt % PS;
        idx = (tt / PS) % ND;
        one = 4'b0001;
        if (cnt < BC) return 4'hF;
        if (LZB && idx > 0 && (disp >> (4 * idx)) == 16'h0) return 4'hF;
        return ~(one << idx);
    endfunction

    task automatic check_model();
        int idx;
        idx = (t / PS) % ND;
        chk("m_an",    32'(an),          32'(exp_an(t, m_disp)));
        chk("m_digit", 32'(digit_out),   32'(m_disp[4*idx +: 4]));
        chk("m_idx",   32'(digit_idx),   32'(idx));
        chk("m_pend",  32'(pending),     32'(m_pend));
        chk("m_fs",    32'(frame_start), 32'((t > 0) && (t % FRAME == 0)));
    endtask

    task automatic tick(input logic ld, input logic [15:0] v);
        load     = ld;
        value_in = v;
        if (t % FRAME == FRAME - 1) begin
            if (ld) begin
                m_disp = v;
                m_pend = 1'b0;
            end else if (m_pend) begin
                m_disp = m_pval;
                m_pend = 1'b0;
            end
        end else if (ld) begin
            m_pval = v;
            m_pend = 1'b1;
        end
        @(negedge clk);
        t++;
        load = 1'b0;
    endtask

    task automatic run_to(input int c);
        while (t < c) tick(1'b0, 16'h0);
    endtask

    task automatic model_clear();
        t      = 0;
        m_disp = 16'h0;
        m_pval = 16'h0;
        m_pend = 1'b0;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        load     = 1'b0;
        value_in = 16'h0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_clear();
    endtask

    function automatic void add(input int c, input logic ld, input logic [15:0] v,
                                input logic [3:0] a, input logic [3:0] d,
                                input logic [1:0] i, input logic p, input logic f);
        vec_t e;
        e.cyc = c; e.ld = ld; e.val = v; e.an = a; e.dig = d;
        e.idx = i; e.pend = p; e.fs = f;
        vt.push_back(e);
    endfunction

    initial begin
        int lz_violations;
        model_clear();

        // Idle frame with display 0, then 16'h1234 loaded mid-frame.
        add( 0, 0, 16'h0,    4'hF, 4'h0, 2'd0, 0, 0);
        add( 1, 0, 16'h0,    4'hF, 4'h0, 2'd0, 0, 0);
        add( 2, 0, 16'h0,    4'hE, 4'h0, 2'd0, 0, 0);
        add( 5, 1, 16'h1234, 4'hE, 4'h0, 2'd0, 0, 0);
        add( 6, 0, 16'h0,    4'hE, 4'h0, 2'd0, 1, 0);
        add( 7, 0, 16'h0,    4'hE, 4'h0, 2'd0, 1, 0);
        add( 8, 0, 16'h0,    4'hF, 4'h0, 2'd1, 1, 0);
        add(10, 0, 16'h0,    LZB ? 4'hF : 4'hD, 4'h0, 2'd1, 1, 0);
        add(15, 0, 16'h0,    LZB ? 4'hF : 4'hD, 4'h0, 2'd1, 1, 0);
        add(18, 0, 16'h0,    LZB ? 4'hF : 4'hB, 4'h0, 2'd2, 1, 0);
        add(26, 0, 16'h0,    LZB ? 4'hF : 4'h7, 4'h0, 2'd3, 1, 0);
        add(31, 0, 16'h0,    LZB ? 4'hF : 4'h7, 4'h0, 2'd3, 1, 0);
        add(32, 0, 16'h0,    4'hF, 4'h4, 2'd0, 0, 1);
        add(33, 0, 16'h0,    4'hF, 4'h4, 2'd0, 0, 0);
        add(34, 0, 16'h0,    4'hE, 4'h4, 2'd0, 0, 0);
        add(40, 0, 16'h0,    4'hF, 4'h3, 2'd1, 0, 0);
        add(42, 0, 16'h0,    4'hD, 4'h3, 2'd1, 0, 0);
        add(48, 0, 16'h0,    4'hF, 4'h2, 2'd2, 0, 0);
        add(56, 0, 16'h0,    4'hF, 4'h1, 2'd3, 0, 0);
        add(58, 0, 16'h0,    4'h7, 4'h1, 2'd3, 0, 0);
        add(64, 0, 16'h0,    4'hF, 4'h4, 2'd0, 0, 1);

        do_reset();
        for (int c = 0; c <= 64; c++) begin
            logic        ld;
            logic [15:0] v;
            ld = 1'b0;
            v  = 16'h0;
            foreach (vt[i]) begin
                if (vt[i].cyc == c) begin
                    chk("tbl_an",    32'(an),          32'(vt[i].an));
                    chk("tbl_digit", 32'(digit_out),   32'(vt[i].dig));
                    chk("tbl_idx",   32'(digit_idx),   32'(vt[i].idx));
                    chk("tbl_pend",  32'(pending),     32'(vt[i].pend));
                    chk("tbl_fs",    32'(frame_start), 32'(vt[i].fs));
                    ld = vt[i].ld;
                    v  = vt[i].val;
                end
            end
            tick(ld, v);
        end

        // Two loads in one frame: only the later one is shown.
        do_reset();
        run_to(3);
        tick(1'b1, 16'hAAAA);
        run_to(20);
        tick(1'b1, 16'hBEEF);
        run_to(25);
        chk("lastwins_nomid", 32'(digit_out), 32'h0);
        run_to(31);
        chk("lastwins_pend", 32'(pending), 32'h1);
        run_to(32);
        chk("lastwins_d0", 32'(digit_out), 32'hF);
        chk("lastwins_pclr", 32'(pending), 32'h0);
        run_to(40);
        chk("lastwins_d1", 32'(digit_out), 32'hE);
        run_to(48);
        chk("lastwins_d2", 32'(digit_out), 32'hE);
        run_to(56);
        chk("lastwins_d3", 32'(digit_out), 32'hB);

        // Load exactly on the boundary cycle bypasses the buffer.
        do_reset();
        run_to(31);
        tick(1'b1, 16'hC0DE);
        chk("bypass_pend", 32'(pending), 32'h0);
        chk("bypass_d0", 32'(digit_out), 32'hE);
        run_to(34);
        chk("bypass_an0", 32'(an), 32'hE);
        run_to(50);
        chk("bypass_d2", 32'(digit_out), 32'h0);
        chk("bypass_an2", 32'(an), 32'hB);
        run_to(56);
        chk("bypass_d3", 32'(digit_out), 32'hC);

        // Asynchronous reset in digit 2's slot discards a pending value.
        do_reset();
        run_to(5);
        tick(1'b1, 16'h5A5A);
        run_to(20);
        #2 reset = 1'b1;
        #1;
        chk("arst_an",   32'(an),          32'hF);
        chk("arst_idx",  32'(digit_idx),   32'h0);
        chk("arst_pend", 32'(pending),     32'h0);
        chk("arst_dig",  32'(digit_out),   32'h0);
        chk("arst_fs",   32'(frame_start), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        run_to(32);
        chk("arst_nocommit", 32'(digit_out), 32'h0);
        chk("arst_pend2",    32'(pending),   32'h0);
        run_to(42);
        chk("arst_an1", 32'(an), 32'(exp_an(42, 16'h0)));

        // Leading-zero behaviour: 0x0005 then 0x0000.
        do_reset();
        run_to(5);
        tick(1'b1, 16'h0005);
        run_to(32);
        lz_violations = 0;
        while (t < 64) begin
            if (an[3:1] != 3'b111) lz_violations++;
            if (t == 34) chk("lz5_an0", 32'(an), 32'hE);
            if (t == 40) tick(1'b1, 16'h0000);
            else tick(1'b0, 16'h0);
        end
        chk("lz5_upper_lit_cycles", 32'(lz_violations), LZB ? 32'd0 : 32'd18);
        run_to(66);
        chk("lz0_an0",  32'(an),        32'hE);
        chk("lz0_dig0", 32'(digit_out), 32'h0);
        run_to(74);
        chk("lz0_an1", 32'(an), LZB ? 32'hF : 32'hD);

        // Randomised traffic checked every cycle against the reference model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            logic        ld;
            logic [15:0] v;
            check_model();
            ld = ($urandom_range(0, 7) == 0);
            if ((t % FRAME == FRAME - 1) && ($urandom_range(0, 1) == 1)) ld = 1'b1;
            v = 16'($urandom);
            case ($urandom_range(0, 3))
                0: v = v & 16'h00FF;
                1: v = v & 16'h000F;
                2: v = 16'h0;
                default: v = v;
            endcase
            tick(ld, v);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
